// File: rtl/prog_launch_ctrl.sv
// prog_launch_ctrl: program launch sequencer between the UART receiver and
// the CPU fetch stage. It decodes a command byte into one of ten program
// slots, loads the PC, runs the pipeline until a non-speculative STA is
// fetched, drains the pipeline and then reports done with a cycle count.
// Optional feature macro: PROG_WATCHDOG_EN (aborts a program whose cycle
// count reaches WDOG_LIMIT).
module prog_launch_ctrl #(
  parameter int SLOT_STRIDE  = 100,
  parameter int DRAIN_CYCLES = 4,
  parameter int WDOG_LIMIT   = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [15:0] fetch_instr,
  input  logic        flush,
  output logic        pc_load,
  output logic [15:0] pc_load_val,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic [15:0] cycle_count,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {E_BLANK = 2'b00, E_CMD = 2'b01,
                            E_BUSY  = 2'b10, E_WDOG = 2'b11} err_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

`ifdef PROG_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  state_t          r_state, w_next_state;
  logic [DW-1:0]   r_drain_cnt, w_drain_cnt_nxt;
  logic            r_pc_load, r_cpu_run, r_busy, r_done, r_err;
  logic [15:0]     r_pc_load_val, w_pc_load_val_nxt;
  logic [15:0]     r_cycle_count, w_cycle_count_nxt;
  err_t            r_err_code, w_err_code_nxt;
  logic            w_err_nxt;

  logic            w_cmd_ok, w_is_sta, w_is_blank, w_wdog_hit;
  logic [3:0]      w_slot;
  logic [15:0]     w_start;

  // Command decode: '1'..'9' select slots 1..9, '0' selects slot 10.
  assign w_cmd_ok   = (rx_data[7:4] == 4'h3) && (rx_data[3:0] <= 4'd9);
  assign w_slot     = (rx_data[3:0] == 4'd0) ? 4'd10 : rx_data[3:0];
  assign w_start    = 16'(int'(w_slot) * SLOT_STRIDE);
  assign w_is_sta   = (fetch_instr[15:12] == 4'b0001);
  assign w_is_blank = (fetch_instr == 16'hFFFF);
  assign w_wdog_hit = WDOG_ON && (r_cycle_count == 16'(WDOG_LIMIT));

  // Next-state, next-output and error selection.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state      = r_state;
    w_drain_cnt_nxt   = r_drain_cnt;
    w_pc_load_val_nxt = r_pc_load_val;
    w_err_nxt         = 1'b0;
    w_err_code_nxt    = r_err_code;
    unique case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (w_cmd_ok) begin
            w_next_state      = S_LOAD;
            w_pc_load_val_nxt = w_start;
          end else begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = E_CMD;
          end
        end
      end
      S_LOAD: w_next_state = S_RUN;
      S_RUN: begin
        if (w_wdog_hit) begin
          w_next_state   = S_IDLE;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = E_WDOG;
        end else if (w_is_blank) begin
          w_next_state   = S_IDLE;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = E_BLANK;
        end else if (w_is_sta && !flush) begin
          // An STA fetched alongside a flush is speculative; keep running.
          w_next_state    = S_DRAIN;
          w_drain_cnt_nxt = DRAIN_INIT;
        end
      end
      S_DRAIN: begin
        if (w_wdog_hit) begin
          w_next_state   = S_IDLE;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = E_WDOG;
        end else if (flush) begin
          w_next_state = S_RUN;
        end else if (r_drain_cnt == '0) begin
          w_next_state = S_DONE;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - 1'b1;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    // A byte arriving while busy is dropped; a program abort in the same
    // cycle takes precedence for the reported cause.
    if (rx_valid && (r_state != S_IDLE) && !w_err_nxt) begin
      w_err_nxt      = 1'b1;
      w_err_code_nxt = E_BUSY;
    end
  end

  // Cycle counter: cleared on launch, counts every LOAD/RUN/DRAIN cycle so
  // the value seen in DONE includes the final drain cycle, saturating.
  always_comb begin
    w_cycle_count_nxt = r_cycle_count;
    if ((r_state == S_IDLE) && (w_next_state == S_LOAD)) begin
      w_cycle_count_nxt = '0;
    end else if (((r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_DRAIN)) &&
                 (r_cycle_count != 16'hFFFF)) begin
      w_cycle_count_nxt = r_cycle_count + 16'd1;
    end
  end

  // State and drain counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // Registered outputs, derived from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_load     <= 1'b0;
      r_pc_load_val <= '0;
      r_cpu_run     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cycle_count <= '0;
      r_err         <= 1'b0;
      r_err_code    <= E_BLANK;
    end else begin
      r_pc_load     <= (w_next_state == S_LOAD);
      r_pc_load_val <= w_pc_load_val_nxt;
      r_cpu_run     <= (w_next_state == S_RUN) || (w_next_state == S_DRAIN);
      r_busy        <= (w_next_state != S_IDLE);
      r_done        <= (w_next_state == S_DONE);
      r_cycle_count <= w_cycle_count_nxt;
      r_err         <= w_err_nxt;
      r_err_code    <= w_err_code_nxt;
    end
  end

  assign pc_load     = r_pc_load;
  assign pc_load_val = r_pc_load_val;
  assign cpu_run     = r_cpu_run;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cycle_count = r_cycle_count;
  assign err         = r_err;
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_prog_launch_ctrl.sv
// Testbench for prog_launch_ctrl: table of command bytes plus directed
// sequences for busy rejection, flush during drain, blank fetch, reset
// mid-program and the watchdog. A small PC/instruction-memory model
// plays the CPU side.
`timescale 1ns/1ps
module tb_prog_launch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [15:0] fetch_instr;
  logic        flush;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic [15:0] cycle_count;
  logic        err;
  logic [1:0]  err_code;

  int n_cmp  = 0;
  int n_fail = 0;

  // CPU-side model state
  logic [15:0] pc = 16'd0;
  logic        sta_en = 1'b0;
  logic [15:0] sta_addr = 16'd0;
  logic        blank_en = 1'b0;
  logic [15:0] blank_addr = 16'd0;
  logic [15:0] br_target = 16'd0;

  prog_launch_ctrl #(
    .SLOT_STRIDE (100),
    .DRAIN_CYCLES(4),
    .WDOG_LIMIT  (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .fetch_instr(fetch_instr),
    .flush      (flush),
    .pc_load    (pc_load),
    .pc_load_val(pc_load_val),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .done       (done),
    .cycle_count(cycle_count),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  rx;
    logic        is_cmd;
    int          sta_off;
    logic [15:0] exp_pcv;
    logic [1:0]  exp_code;
    int          exp_ticks;
    int          exp_count;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (sta_en && a == sta_addr)          return 16'h1234;
    else if (blank_en && a == blank_addr) return 16'hFFFF;
    else                                  return 16'h3000 | {4'h0, a[11:0]};
  endfunction

  // Advance one clock; the PC model follows the DUT's load/run controls.
  task automatic tick();
    logic        pl, run, fl;
    logic [15:0] plv;
    pl = pc_load; run = cpu_run; fl = flush; plv = pc_load_val;
    @(posedge clk); #1;
    if (pl)             pc = plv;
    else if (fl && run) pc = br_target;
    else if (run)       pc = pc + 16'd1;
    fetch_instr = mem_rd(pc);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output int ticks, output logic seen);
    ticks = 0;
    seen  = 1'b0;
    while (ticks < budget && !seen) begin
      tick();
      ticks++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_load"},     pc_load,     0);
    check({tag, "_pc_load_val"}, pc_load_val, 0);
    check({tag, "_cpu_run"},     cpu_run,     0);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_done"},        done,        0);
    check({tag, "_cycle_count"}, cycle_count, 0);
    check({tag, "_err"},         err,         0);
    check({tag, "_err_code"},    err_code,    0);
  endtask

  initial begin
    int   ticks;
    logic seen;

    vecs[0] = '{8'h31, 1'b1,  7, 16'd100,  2'b00, 13, 13};
    vecs[1] = '{8'h41, 1'b0,  0, 16'd0,    2'b01,  0,  0};
    vecs[2] = '{8'h39, 1'b1,  0, 16'd900,  2'b00,  6,  6};
    vecs[3] = '{8'h2F, 1'b0,  0, 16'd0,    2'b01,  0,  0};
    vecs[4] = '{8'h30, 1'b1,  3, 16'd1000, 2'b00,  9,  9};
    vecs[5] = '{8'h3A, 1'b0,  0, 16'd0,    2'b01,  0,  0};
    vecs[6] = '{8'h34, 1'b1, 12, 16'd400,  2'b00, 18, 18};
    vecs[7] = '{8'hB1, 1'b0,  0, 16'd0,    2'b01,  0,  0};

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; flush = 1'b0;
    fetch_instr = mem_rd(pc);
    tick(); tick();
    check_reset_outputs("reset_state");
    reset = 1'b0;
    tick();
    check("idle_after_reset_busy", busy, 0);

    // ---------------- table-driven command decode ----------------
    for (int i = 0; i < 8; i++) begin
      sta_en   = vecs[i].is_cmd;
      sta_addr = vecs[i].exp_pcv + 16'(vecs[i].sta_off);
      send_byte(vecs[i].rx);
      if (vecs[i].is_cmd) begin
        check($sformatf("v%0d_pc_load", i),     pc_load,     1);
        check($sformatf("v%0d_pc_load_val", i), pc_load_val, vecs[i].exp_pcv);
        check($sformatf("v%0d_load_busy", i),   busy,        1);
        check($sformatf("v%0d_load_run", i),    cpu_run,     0);
        check($sformatf("v%0d_load_count", i),  cycle_count, 0);
        tick();
        check($sformatf("v%0d_run1_pc_load", i), pc_load, 0);
        check($sformatf("v%0d_run1_cpu_run", i), cpu_run, 1);
        run_to_done(40, ticks, seen);
        check($sformatf("v%0d_done_seen", i),    seen,        1);
        check($sformatf("v%0d_done_ticks", i),   ticks + 1,   vecs[i].exp_ticks);
        check($sformatf("v%0d_done_cpu_run", i), cpu_run,     0);
        check($sformatf("v%0d_done_count", i),   cycle_count, vecs[i].exp_count);
        tick();
        check($sformatf("v%0d_post_done", i),  done,        0);
        check($sformatf("v%0d_post_busy", i),  busy,        0);
        check($sformatf("v%0d_post_count", i), cycle_count, vecs[i].exp_count);
      end else begin
        check($sformatf("v%0d_err", i),      err,      1);
        check($sformatf("v%0d_err_code", i), err_code, vecs[i].exp_code);
        check($sformatf("v%0d_no_load", i),  pc_load,  0);
        check($sformatf("v%0d_busy", i),     busy,     0);
        tick();
        check($sformatf("v%0d_err_drop", i), err,      0);
        check($sformatf("v%0d_code_hold", i), err_code, vecs[i].exp_code);
        check($sformatf("v%0d_busy2", i),    busy,     0);
      end
    end

    // ---------------- rx while busy ----------------
    sta_en = 1'b1; sta_addr = 16'd107;
    send_byte(8'h31);
    tick(); tick(); tick();                    // RUN cycle 3
    send_byte(8'h32);
    check("busy_rx_err",      err,         1);
    check("busy_rx_code",     err_code,    2'b10);
    check("busy_rx_no_load",  pc_load,     0);
    check("busy_rx_run",      cpu_run,     1);
    tick();
    check("busy_rx_err_drop", err,         0);
    check("busy_rx_code_hold", err_code,   2'b10);
    run_to_done(30, ticks, seen);
    check("busy_rx_done_seen",  seen,        1);
    check("busy_rx_done_ticks", ticks + 5,   13);
    check("busy_rx_count",      cycle_count, 13);
    check("busy_rx_pcv",        pc_load_val, 100);
    tick();

    // ---------------- flush during drain ----------------
    sta_en = 1'b1; sta_addr = 16'd1009; br_target = 16'd1008;
    send_byte(8'h30);
    check("flush_pcv", pc_load_val, 1000);
    for (int t = 1; t <= 30; t++) begin
      tick();
      check($sformatf("flush_t%0d_done", t),    done,    (t == 30));
      check($sformatf("flush_t%0d_cpu_run", t), cpu_run, (t < 30));
      flush = (t == 10) || (t == 13) || (t == 19) || (t == 23);
    end
    check("flush_count", cycle_count, 30);
    flush = 1'b0;
    tick();
    check("flush_post_done", done, 0);
    check("flush_post_busy", busy, 0);

    // ---------------- blank fetch ----------------
    sta_en = 1'b0; blank_en = 1'b1; blank_addr = 16'd502;
    send_byte(8'h35);
    check("blank_pcv", pc_load_val, 500);
    tick(); tick(); tick();                    // RUN cycle 3 fetches 502
    tick();
    check("blank_err",      err,         1);
    check("blank_code",     err_code,    2'b00);
    check("blank_cpu_run",  cpu_run,     0);
    check("blank_busy",     busy,        0);
    check("blank_done",     done,        0);
    check("blank_count",    cycle_count, 4);
    tick();
    check("blank_err_drop", err,  0);
    check("blank_no_done",  done, 0);
    blank_en = 1'b0;

    // ---------------- reset mid-program ----------------
    send_byte(8'h33);
    tick(); tick(); tick();                    // RUN cycle 3
    send_byte(8'h37);
    check("rst_pre_err", err, 1);
    reset = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    tick();
    check("rst_after_busy", busy,    0);
    check("rst_after_run",  cpu_run, 0);

    // ---------------- watchdog / runaway program ----------------
    sta_en = 1'b0;
    send_byte(8'h32);
`ifdef PROG_WATCHDOG_EN
    ticks = 0;
    seen  = 1'b0;
    while (ticks < 60 && !seen) begin
      tick();
      ticks++;
      if (err) seen = 1'b1;
    end
    check("wdog_err_seen",  seen,     1);
    check("wdog_err_ticks", ticks,    21);
    check("wdog_code",      err_code, 2'b11);
    check("wdog_cpu_run",   cpu_run,  0);
    check("wdog_done",      done,     0);
`else
    seen = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (err || done) seen = 1'b1;
    end
    check("nowdog_cpu_run",  cpu_run,     1);
    check("nowdog_busy",     busy,        1);
    check("nowdog_no_abort", seen,        0);
    check("nowdog_count",    cycle_count, 100);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("final_idle_run", cpu_run, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_launch_ctrl.md
# prog_launch_ctrl

Program launch sequencer between the UART receiver and the CPU fetch stage. It decodes a UART command byte into one of ten fixed instruction-memory program slots and loads the start address into the PC. It then runs the pipeline and watches fetched instructions for the terminating STA, draining the pipeline before reporting done with a cycle count. It owns run/stop of the CPU; the CPU never starts a program on its own.

## Interface
- SLOT_STRIDE, 100: word distance between program slots; slot k starts at k*SLOT_STRIDE.
- DRAIN_CYCLES, 4: cycles the pipeline keeps running after the terminating STA is fetched.
- WDOG_LIMIT, 1023: maximum RUN+DRAIN cycles before abort (WATCHDOG_EN only).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_data holds a received byte.
- rx_data  in  8  received UART byte.
- fetch_instr  in  16  instruction currently presented by instruction memory.
- flush  in  1  CPU branch-taken flush; the speculatively fetched instruction is discarded.
- pc_load  out  1  one-cycle PC load strobe.
- pc_load_val  out  16  PC value loaded on pc_load.
- cpu_run  out  1  PC increment / pipeline advance enable.
- busy  out  1  a program is loading, running or draining.
- done  out  1  one-cycle completion pulse.
- cycle_count  out  16  cycles spent in RUN+DRAIN for the current/last program.
- err  out  1  one-cycle error pulse.
- err_code  out  2  cause of the last error, held until the next err.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- Command decode in IDLE on rx_valid: ASCII '1'..'9' (0x31..0x39) selects slot 1..9; '0' (0x30) selects slot 10. Any other byte: err pulse, err_code=2'b01, stay IDLE.
- IDLE -> LOAD on a valid command; pc_load_val = slot*SLOT_STRIDE (16-bit unsigned, e.g. '0' -> 1000).
- LOAD: pc_load=1 for exactly one cycle, cycle_count cleared to 0; next state RUN.
- RUN: cpu_run=1, cycle_count +1 per cycle, saturating at 16'hFFFF.
  - fetch_instr[15:12]==4'b0001 (STA) with flush=0 -> DRAIN, drain counter loaded with DRAIN_CYCLES-1.
  - fetch_instr==16'hFFFF (blank memory) -> err pulse, err_code=2'b00, cpu_run drops, -> IDLE; no done.
- DRAIN: cpu_run=1, cycle_count keeps counting, drain counter decrements.
  - flush=1 in any DRAIN cycle -> back to RUN (the STA was speculative behind a taken branch).
  - Counter reaches 0 with flush=0 -> DONE.
- DONE: cpu_run=0, done=1 for one cycle, -> IDLE. cycle_count holds until the next LOAD.
- rx_valid while busy: byte ignored, err pulse, err_code=2'b10, the program continues undisturbed.
- Simultaneous STA detect and flush in RUN: flush wins, stay RUN.
- Simultaneous blank-fetch and watchdog expiry: watchdog code reported.

## Timing
- Reset values: pc_load=0, pc_load_val=0, cpu_run=0, busy=0, done=0, cycle_count=0, err=0, err_code=2'b00; state IDLE, drain counter 0.
- Reset mid-program takes effect on the next edge: every output returns to its reset value, and any in-progress done/err pulse is cancelled.
- rx_valid at edge N -> pc_load=1 and busy=1 during cycle N+1 -> cpu_run=1 from cycle N+2.
- STA seen in cycle M -> DRAIN for cycles M+1..M+DRAIN_CYCLES -> done=1 in cycle M+DRAIN_CYCLES+1, with cpu_run=0 in that cycle.
- busy is 1 in LOAD, RUN, DRAIN and DONE and falls with the edge that ends DONE.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- PROG_WATCHDOG_EN defined: a cycle_count equal to WDOG_LIMIT in RUN or DRAIN aborts the program: cpu_run drops, err pulse, err_code=2'b11, -> IDLE, no done.
- PROG_WATCHDOG_EN undefined: no abort; a non-terminating program runs until reset, and cycle_count saturates at 16'hFFFF. err_code 2'b11 is never produced.

## Test plan
- Reset, then rx '1' (0x31) with memory holding STA at 107 and DRAIN_CYCLES=4 -> pc_load with pc_load_val=100 one cycle later; done exactly 5 cycles after the STA fetch cycle; cycle_count=13 (8 RUN + 4 DRAIN + 1).
- rx '0' -> pc_load_val=1000. Assert flush during DRAIN after the speculative STA at 1009 three times, then no flush -> state returns to RUN each time; single done pulse only after the unflushed drain.
- rx 'A' (0x41) in IDLE -> err=1 for one cycle, err_code=2'b01, no pc_load, busy stays 0.
- rx '2' while running slot 1 -> err_code=2'b10, pc_load not reasserted, slot 1 completes with normal done.
- Run slot 5 with fetch_instr forced to 16'hFFFF in the third RUN cycle -> err_code=2'b00, cpu_run=0 the next cycle, no done; assert reset during RUN of a second program -> all outputs return to reset values on the next edge.
- PROG_WATCHDOG_EN with WDOG_LIMIT=20 and a program with no STA -> err_code=2'b11 when cycle_count reaches 20; without the macro, cpu_run is still 1 after 100 cycles.
